apb_master_bridge1: RTL
=======================

APB_MASTER_BRIDGE1 -- requirements
Module: apb_master_bridge1

Interface
REQ-001 The block SHALL have one clock, pclock1; reset preset1 is asynchronous and active-low.
REQ-002 Parameter PADDR_WIDTH1, 32, APB address width.
REQ-003 Parameter PWDATA_WIDTH1, 32, APB write-data width.
REQ-004 Parameter PRDATA_WIDTH1, 32, APB read-data width.
REQ-005 Parameter TIMEOUT_CYCLES1, 16, maximum ACCESS wait cycles; 0 disables timeout.
REQ-006 Ports SHALL be:
pclock1  input  1  APB clock
preset1  input  1  async active-low reset
req_valid1  input  1  request offered
req_ready1  output  1  request accepted when high with req_valid1
req_write1  input  1  1=write, 0=read
req_addr1  input  PADDR_WIDTH1  request address
req_wdata1  input  PWDATA_WIDTH1  request write data
rsp_valid1  output  1  one-cycle response strobe
rsp_rdata1  output  PRDATA_WIDTH1  read data (0 for writes/timeouts)
rsp_err1  output  1  pslverr1 or timeout
rsp_timeout1  output  1  transfer aborted by timeout
paddr1  output  PADDR_WIDTH1  APB address
prwd1  output  1  APB direction, 1=write
pwdata1  output  PWDATA_WIDTH1  APB write data
psel1  output  1  APB select (single slave)
penable1  output  1  APB enable
prdata1  input  PRDATA_WIDTH1  APB read data
pslverr1  input  1  APB slave error
pready1  input  1  APB ready

Function
REQ-007 FSM states SHALL be IDLE, SETUP, ACCESS; reset state IDLE.
REQ-008 req_ready1 SHALL be high only in IDLE, decoded from state.
REQ-009 In IDLE with req_valid1=1: register addr/write/wdata onto paddr1/prwd1/pwdata1; next state SETUP.
REQ-010 SETUP: psel1=1, penable1=0 for exactly one cycle; next state ACCESS.
REQ-011 ACCESS: psel1=1, penable1=1; paddr1/prwd1/pwdata1 unchanged from SETUP.
REQ-012 ACCESS with pready1=1: transfer completes; next state IDLE; pslverr1 and prdata1 (reads only) registered.
REQ-013 rsp_valid1 SHALL be high exactly one cycle, the cycle after completion or timeout, coincident with req_ready1=1.
REQ-014 rsp_rdata1/rsp_err1/rsp_timeout1 SHALL hold values from the last response until the next response.
REQ-015 pslverr1/prdata1 SHALL be ignored when pready1=0.
REQ-016 Wait counter SHALL clear on SETUP and increment each ACCESS cycle with pready1=0.
REQ-017 Counter reaching TIMEOUT_CYCLES1 (nonzero) with pready1=0: abort to IDLE; response has rsp_err1=1, rsp_timeout1=1, rsp_rdata1=0.
REQ-018 pready1=1 in the cycle the counter reaches its limit SHALL complete normally (pready1 wins).
REQ-019 Minimum transfer: 2 APB cycles plus 1 IDLE; new request accepted in the rsp_valid1 cycle.
REQ-020 In IDLE psel1=penable1=0; paddr1/prwd1/pwdata1 hold their last values.

Reset
REQ-021 preset1 low SHALL immediately force state IDLE, counter 0, and all outputs 0 except req_ready1=1.
REQ-022 Reset mid-transfer SHALL drop psel1/penable1 asynchronously and produce no rsp_valid1.

Structure
REQ-023 Package apb_master_pkg1 SHALL hold the state typedef apb_mst_state_e and default width/timeout constants.
REQ-024 Wait counter SHALL be sub-module apb_mst_timer1 (clear, enable, limit in; expired out).

Verification
REQ-025 Write 0x0000_0010/0xDEAD_BEEF, pready1=1 in first ACCESS -> SETUP then ACCESS one cycle each, rsp_valid1 pulse, rsp_err1=0.
REQ-026 Read 0x0000_0020, pready1 low 3 cycles, prdata1=0x1234_5678 -> paddr1 stable throughout, rsp_rdata1=0x1234_5678 after 5 psel1 cycles.
REQ-027 Read with pready1=1 and pslverr1=1 -> rsp_err1=1, rsp_timeout1=0.
REQ-028 TIMEOUT_CYCLES1=4, pready1 held low -> abort after 4 wait cycles, rsp_err1=1, rsp_timeout1=1, rsp_rdata1=0.
REQ-029 preset1 low in ACCESS -> psel1/penable1 0 same cycle, no rsp_valid1; next request completes normally.
REQ-030 req_valid1 held high for two requests -> second accepted in first rsp_valid1 cycle, psel1 low for exactly one cycle between.

Source files
------------

// File: rtl/apb_master_pkg1.sv
// ============================================================================
// Module      : apb_master_pkg1
// Description : Shared state encoding, default widths and helpers for the
//               APB master bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_master_pkg1;

    // Bridge transfer phases
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_mst_state_e;

    localparam int c_paddr_width_dflt  = 32;
    localparam int c_pwdata_width_dflt = 32;
    localparam int c_prdata_width_dflt = 32;
    localparam int c_timeout_dflt      = 16;

    // Counter width able to hold the value t (at least one bit)
    function automatic int cnt_width(input int t);
        if (t < 1) begin
            return 1;
        end
        return $clog2(t + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_mst_timer1.sv
// ============================================================================
// Module      : apb_mst_timer1
// Description : ACCESS-phase wait counter. Clears on request, counts enabled
//               cycles and flags when the count equals a nonzero limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_mst_timer1 #(
    parameter int CNT_WIDTH = 5
) (
    input  logic                 pclock1,
    input  logic                 preset1,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic                 expired
);

    logic [CNT_WIDTH-1:0] r_count;

    // A zero limit disables expiry entirely
    assign expired = (limit != '0) && (r_count == limit);

    // Count waited cycles; hold once expired or at the counter ceiling
    always_ff @(posedge pclock1 or negedge preset1) begin
        if (!preset1) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_master_bridge1.sv
// ============================================================================
// Module      : apb_master_bridge1
// Description : Single-slave APB master. Accepts one request at a time from a
//               valid/ready port, runs SETUP/ACCESS, and returns a one-cycle
//               response with read data, slave error and timeout status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_bridge1
    import apb_master_pkg1::*;
#(
    parameter int PADDR_WIDTH1    = c_paddr_width_dflt,
    parameter int PWDATA_WIDTH1   = c_pwdata_width_dflt,
    parameter int PRDATA_WIDTH1   = c_prdata_width_dflt,
    parameter int TIMEOUT_CYCLES1 = c_timeout_dflt
) (
    input  logic                     pclock1,
    input  logic                     preset1,
    input  logic                     req_valid1,
    output logic                     req_ready1,
    input  logic                     req_write1,
    input  logic [PADDR_WIDTH1-1:0]  req_addr1,
    input  logic [PWDATA_WIDTH1-1:0] req_wdata1,
    output logic                     rsp_valid1,
    output logic [PRDATA_WIDTH1-1:0] rsp_rdata1,
    output logic                     rsp_err1,
    output logic                     rsp_timeout1,
    output logic [PADDR_WIDTH1-1:0]  paddr1,
    output logic                     prwd1,
    output logic [PWDATA_WIDTH1-1:0] pwdata1,
    output logic                     psel1,
    output logic                     penable1,
    input  logic [PRDATA_WIDTH1-1:0] prdata1,
    input  logic                     pslverr1,
    input  logic                     pready1
);

    localparam int CNT_WIDTH = cnt_width(TIMEOUT_CYCLES1);
    localparam logic [CNT_WIDTH-1:0] c_limit = CNT_WIDTH'(TIMEOUT_CYCLES1);

    apb_mst_state_e r_state;
    logic           w_timer_clear;
    logic           w_timer_enable;
    logic           w_expired;

    // Requests are only taken while no transfer is in flight
    assign req_ready1 = (r_state == ST_IDLE);

    // Counter restarts each transfer; only stalled ACCESS cycles count
    assign w_timer_clear  = (r_state == ST_SETUP);
    assign w_timer_enable = (r_state == ST_ACCESS) && !pready1;

    apb_mst_timer1 #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .pclock1 (pclock1),
        .preset1 (preset1),
        .clear   (w_timer_clear),
        .enable  (w_timer_enable),
        .limit   (c_limit),
        .expired (w_expired)
    );

    // Transfer sequencer with registered APB and response outputs
    always_ff @(posedge pclock1 or negedge preset1) begin
        if (!preset1) begin
            r_state      <= ST_IDLE;
            paddr1       <= '0;
            prwd1        <= 1'b0;
            pwdata1      <= '0;
            psel1        <= 1'b0;
            penable1     <= 1'b0;
            rsp_valid1   <= 1'b0;
            rsp_rdata1   <= '0;
            rsp_err1     <= 1'b0;
            rsp_timeout1 <= 1'b0;
        end else begin
            rsp_valid1 <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid1) begin
                        paddr1  <= req_addr1;
                        prwd1   <= req_write1;
                        pwdata1 <= req_wdata1;
                        psel1   <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable1 <= 1'b1;
                    r_state  <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A ready slave wins over a timeout in the same cycle
                    if (pready1) begin
                        psel1        <= 1'b0;
                        penable1     <= 1'b0;
                        rsp_valid1   <= 1'b1;
                        rsp_err1     <= pslverr1;
                        rsp_timeout1 <= 1'b0;
                        rsp_rdata1   <= prwd1 ? '0 : prdata1;
                        r_state      <= ST_IDLE;
                    end else if (w_expired) begin
                        psel1        <= 1'b0;
                        penable1     <= 1'b0;
                        rsp_valid1   <= 1'b1;
                        rsp_err1     <= 1'b1;
                        rsp_timeout1 <= 1'b1;
                        rsp_rdata1   <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    psel1    <= 1'b0;
                    penable1 <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
